// File: rtl/packed_lane_pkg.sv
// Shared types and helpers for the packed lane writer.
// Holds the opcode and FSM enums plus the bit-numbering map.
package packed_lane_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'd0,
        OP_LANES = 2'd1,
        OP_LBITS = 2'd2,
        OP_TBITS = 2'd3
    } op_e;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_e;

    // Declared bit index to physical bit position within a field of width w.
    function automatic int map_bit(input int b, input int w, input bit asc);
        return asc ? (w - 1 - b) : b;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lane_index_map.sv
// Maps a signed lane index plus slice length onto the lowest physical lane
// position, and flags whether the whole slice lies inside the lane array.
module lane_index_map
    import packed_lane_pkg::*;
#(
    parameter int unsigned LANES    = 8,
    parameter int          IDX_BASE = 0,
    parameter int unsigned LANE_ASC = 0,
    parameter int unsigned IDX_W    = 8,
    localparam int unsigned CNT_W   = $clog2(LANES + 1),
    localparam int unsigned PW      = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic signed [IDX_W-1:0] idx,
    input  logic [CNT_W-1:0]        cnt,
    output logic [PW-1:0]           pmin,
    output logic                    in_range
);

    int lo_c;
    int hi_c;

    // lo/hi are the slice ends relative to the lowest declared index
    always_comb begin
        lo_c     = int'(idx) - IDX_BASE;
        hi_c     = lo_c + int'(cnt) - 1;
        in_range = (cnt != '0) && (int'(cnt) <= int'(LANES)) &&
                   (lo_c >= 0) && (hi_c < int'(LANES));
        pmin     = (LANE_ASC != 0) ? PW'(int'(LANES) - 1 - hi_c) : PW'(lo_c);
    end

endmodule

// File: rtl/packed_lane_writer.sv
// Sequential writer assembling a packed {lane array; tail} vector from
// clear, lane-slice, single-lane bit-range and tail bit-range commands.
module packed_lane_writer
    import packed_lane_pkg::*;
#(
    parameter int unsigned LANES    = 8,
    parameter int unsigned LANE_W   = 8,
    parameter int unsigned TAIL_W   = 16,
    parameter int          IDX_BASE = 0,
    parameter int unsigned LANE_ASC = 0,
    parameter int unsigned BIT_ASC  = 0,
    parameter int unsigned TAIL_ASC = 0,
    parameter int unsigned IDX_W    = 8,
    localparam int unsigned CNT_W   = $clog2(LANES + 1),
    localparam int unsigned FW      = max_u(LANE_W, TAIL_W),
    localparam int unsigned BSEL_W  = $clog2(FW),
    localparam int unsigned DW      = LANES * LANE_W,
    localparam int unsigned VW      = DW + TAIL_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic signed [IDX_W-1:0] req_idx,
    input  logic [CNT_W-1:0]        req_cnt,
    input  logic [BSEL_W-1:0]       req_bl,
    input  logic [BSEL_W-1:0]       req_bh,
    input  logic [DW-1:0]           req_data,
    output logic [VW-1:0]           vec,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int unsigned PW = (LANES > 1) ? $clog2(LANES) : 1;

    state_e            state_q, state_d;
    op_e               op;
    logic [VW-1:0]     vec_d;
    logic [DW-1:0]     data_q, data_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              done_d, err_d;

    logic [CNT_W-1:0]  map_cnt;
    logic [PW-1:0]     pmin;
    logic              in_range;

    logic              bit_asc;
    logic              bits_ok;
    int                fw_i, bl_i, bh_i, qa, qb, qlo, qhi;
    logic [FW-1:0]     mask;
    logic [FW-1:0]     wdata;

    logic              lane_wr;
    logic              lbits_wr;
    logic [PW-1:0]     lane_pos;
    logic [LANE_W-1:0] lane_val;

    assign op        = op_e'(req_op);
    assign req_ready = (state_q == S_IDLE) && !rst;
    assign map_cnt   = (op == OP_LANES) ? req_cnt : CNT_W'(1);

    lane_index_map #(
        .LANES    (LANES),
        .IDX_BASE (IDX_BASE),
        .LANE_ASC (LANE_ASC),
        .IDX_W    (IDX_W)
    ) u_map (
        .idx      (req_idx),
        .cnt      (map_cnt),
        .pmin     (pmin),
        .in_range (in_range)
    );

    // Bit-range geometry: physical span [qlo, qhi] and the right-aligned data moved into it
    always_comb begin
        fw_i    = (op == OP_TBITS) ? int'(TAIL_W) : int'(LANE_W);
        bit_asc = (op == OP_TBITS) ? (TAIL_ASC != 0) : (BIT_ASC != 0);
        bl_i    = int'(req_bl);
        bh_i    = int'(req_bh);
        bits_ok = (bl_i <= bh_i) && (bh_i < fw_i);
        qa      = map_bit(bl_i, fw_i, bit_asc);
        qb      = map_bit(bh_i, fw_i, bit_asc);
        qlo     = (qa < qb) ? qa : qb;
        qhi     = (qa < qb) ? qb : qa;
        for (int j = 0; j < int'(FW); j++) begin
            mask[j] = (j >= qlo) && (j <= qhi);
        end
        wdata   = FW'(req_data) << qlo;
    end

    function automatic logic [FW-1:0] merge(input logic [FW-1:0] old,
                                            input logic [FW-1:0] m,
                                            input logic [FW-1:0] d);
        return (old & ~m) | (d & m);
    endfunction

    // Next-state, vector update and completion pulses
    always_comb begin
        state_d  = state_q;
        vec_d    = vec;
        data_d   = data_q;
        pos_d    = pos_q;
        rem_d    = rem_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        lane_wr  = 1'b0;
        lbits_wr = 1'b0;
        lane_pos = pmin;
        lane_val = req_data[LANE_W-1:0];

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    case (op)
                        OP_CLEAR: begin
                            vec_d  = '0;
                            done_d = 1'b1;
                        end
                        OP_LANES: begin
                            if (!in_range) begin
                                err_d = 1'b1;
                            end else begin
                                lane_wr = 1'b1;
                                if (req_cnt > CNT_W'(1)) begin
                                    state_d = S_STREAM;
                                    data_d  = req_data >> LANE_W;
                                    pos_d   = pmin + PW'(1);
                                    rem_d   = req_cnt - CNT_W'(1);
                                end else begin
                                    done_d = 1'b1;
                                end
                            end
                        end
                        OP_LBITS: begin
                            if (!in_range || !bits_ok) begin
                                err_d = 1'b1;
                            end else begin
                                lbits_wr = 1'b1;
                                done_d   = 1'b1;
                            end
                        end
                        OP_TBITS: begin
                            if (!bits_ok) begin
                                err_d = 1'b1;
                            end else begin
                                vec_d[TAIL_W-1:0] = TAIL_W'(merge(FW'(vec[TAIL_W-1:0]), mask, wdata));
                                done_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_STREAM: begin
                lane_wr  = 1'b1;
                lane_pos = pos_q;
                lane_val = data_q[LANE_W-1:0];
                data_d   = data_q >> LANE_W;
                pos_d    = pos_q + PW'(1);
                rem_d    = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Constant-base lane slots keep the lane write free of variable part-selects
        for (int p = 0; p < int'(LANES); p++) begin
            if (PW'(p) == lane_pos) begin
                if (lane_wr) begin
                    vec_d[TAIL_W + p*LANE_W +: LANE_W] = lane_val;
                end
                if (lbits_wr) begin
                    vec_d[TAIL_W + p*LANE_W +: LANE_W] =
                        LANE_W'(merge(FW'(vec[TAIL_W + p*LANE_W +: LANE_W]), mask, wdata));
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec     <= '0;
            data_q  <= '0;
            pos_q   <= '0;
            rem_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            vec     <= vec_d;
            data_q  <= data_d;
            pos_q   <= pos_d;
            rem_q   <= rem_d;
            busy    <= (state_d == S_STREAM);
            done    <= done_d;
            err     <= err_d;
        end
    end

endmodule
